// File: rtl/snn_pkg.sv
// ----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the IF-neuron layer datapath:
//   - seq_state_t : layer sequencer state encoding
//   - VW / DW     : default membrane-voltage and activation/weight widths
//   - THRESHOLD   : firing threshold, shared with the IF neuron wrapper
// ----------------------------------------------------------------------------
package snn_pkg;

    localparam int VW        = 16;
    localparam int DW        = 8;
    localparam int THRESHOLD = 127;

    typedef enum logic [2:0] {
        IDLE,
        RD_V,
        LOAD,
        ACC,
        FIRE,
        WB,
        DONE
    } seq_state_t;

endpackage

// File: rtl/if_layer_sequencer_pipe.sv
// ----------------------------------------------------------------------------
// if_input_stream_pipe
// Aligns the activation/weight stream with the synchronous-read memories.
// A slot issued by the sequencer in cycle k is presented to the neuron in
// cycle k+1, when act_rdata/w_rdata carry the addressed data.
//
// Optional build macro: SKIP_ZERO_ACT_EN
//   defined   : slots whose activation reads back as zero are not presented
//               (nrn_input_valid stays low); stream timing is unchanged.
//   undefined : every issued slot is presented.
//
// Ports:
//   clk, rst         clock / synchronous active-high reset
//   issue            a memory read was addressed this cycle
//   act_rdata        activation read data (valid 1 cycle after address)
//   w_rdata          weight read data (valid 1 cycle after address)
//   nrn_input_valid  operand strobe to the neuron
//   nrn_activation   activation operand, holds last presented value
//   nrn_weight       weight operand, holds last presented value
// ----------------------------------------------------------------------------
module if_input_stream_pipe #(
    parameter int DW = snn_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [DW-1:0] act_rdata,
    input  logic [DW-1:0] w_rdata,
    output logic          nrn_input_valid,
    output logic [DW-1:0] nrn_activation,
    output logic [DW-1:0] nrn_weight
);
    import snn_pkg::*;

    logic          slot_q, slot_d;
    logic [DW-1:0] act_q, act_d;
    logic [DW-1:0] wgt_q, wgt_d;
    logic          present;

    always_comb begin
        slot_d = issue;
`ifdef SKIP_ZERO_ACT_EN
        present = slot_q && (act_rdata != '0);
`else
        present = slot_q;
`endif
        act_d = act_q;
        wgt_d = wgt_q;
        // Operands pass straight from the memories when presented and are
        // captured so they hold steady on every other cycle.
        if (present) begin
            act_d = act_rdata;
            wgt_d = w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= 1'b0;
            act_q  <= '0;
            wgt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            act_q  <= act_d;
            wgt_q  <= wgt_d;
        end
    end

    assign nrn_input_valid = present;
    assign nrn_activation  = act_d;
    assign nrn_weight      = wgt_d;

endmodule

// File: rtl/if_layer_sequencer.sv
// ----------------------------------------------------------------------------
// if_layer_sequencer
// Time-multiplexes one IF neuron over N_NEURONS logical neurons. One start
// pulse runs a full layer step; per neuron: read stored voltage (RD_V), load
// it (LOAD), stream N_INPUTS activation/weight pairs (ACC, N_INPUTS+1
// cycles), fire (FIRE), write voltage back and report the spike (WB).
// Per-neuron latency N_INPUTS+5; full pass N_NEURONS*(N_INPUTS+5)+1 cycles
// from start to done.
//
// Optional build macro: SKIP_ZERO_ACT_EN (zero activations not presented,
// handled in if_input_stream_pipe).
//
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   start, arithm_mode       pass request (IDLE only) / arithmetic select
//   busy, done               pass in progress / end-of-pass pulse
//   act_addr, act_rdata      activation memory (1-cycle read)
//   w_addr, w_rdata          weight memory, address n*N_INPUTS+i
//   vmem_*                   voltage memory read/write
//   nrn_*                    IF neuron control and operands
//   spike_valid/idx/bit      per-neuron spike report
// ----------------------------------------------------------------------------
module if_layer_sequencer #(
    parameter int N_NEURONS = 20,
    parameter int N_INPUTS  = 64,
    parameter int VW        = snn_pkg::VW,
    parameter int DW        = snn_pkg::DW,
    localparam int AW  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int WAW = (N_NEURONS * N_INPUTS > 1) ? $clog2(N_NEURONS * N_INPUTS) : 1,
    localparam int NW  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           arithm_mode,
    output logic           busy,
    output logic           done,
    output logic [AW-1:0]  act_addr,
    input  logic [DW-1:0]  act_rdata,
    output logic [WAW-1:0] w_addr,
    input  logic [DW-1:0]  w_rdata,
    output logic [NW-1:0]  vmem_addr,
    input  logic [VW-1:0]  vmem_rdata,
    output logic           vmem_we,
    output logic [VW-1:0]  vmem_wdata,
    output logic           nrn_load_en,
    output logic           nrn_input_valid,
    output logic           nrn_output_en,
    output logic           nrn_arithm,
    output logic [DW-1:0]  nrn_activation,
    output logic [DW-1:0]  nrn_weight,
    output logic [VW-1:0]  nrn_input_mem_vol,
    input  logic [VW-1:0]  nrn_out_mem_vol,
    input  logic           nrn_spike,
    output logic           spike_valid,
    output logic [NW-1:0]  spike_idx,
    output logic           spike_bit
);
    import snn_pkg::*;

    // Slot counter must reach N_INPUTS: the final ACC cycle only drains data.
    localparam int KW = $clog2(N_INPUTS + 1);

    localparam logic [KW-1:0]  K_LAST   = KW'(N_INPUTS);
    localparam logic [NW-1:0]  N_LAST   = NW'(N_NEURONS - 1);
    localparam logic [WAW-1:0] W_STRIDE = WAW'(N_INPUTS);

    seq_state_t    state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [KW-1:0] k_q, k_d;
    logic          arithm_q, arithm_d;
    logic          issue;
    logic          wb_we;
    logic          wb_spike;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        k_d      = k_q;
        arithm_d = arithm_q;

        issue             = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        act_addr          = '0;
        w_addr            = '0;
        vmem_addr         = '0;
        vmem_wdata        = '0;
        wb_we             = 1'b0;
        wb_spike          = 1'b0;
        nrn_load_en       = 1'b0;
        nrn_output_en     = 1'b0;
        nrn_input_mem_vol = '0;
        spike_idx         = '0;
        spike_bit         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    arithm_d = arithm_mode;
                    n_d      = '0;
                    k_d      = '0;
                    state_d  = RD_V;
                end
            end
            RD_V: begin
                busy      = 1'b1;
                vmem_addr = n_q;
                state_d   = LOAD;
            end
            LOAD: begin
                busy              = 1'b1;
                nrn_load_en       = 1'b1;
                nrn_input_mem_vol = vmem_rdata;
                k_d               = '0;
                state_d           = ACC;
            end
            ACC: begin
                busy = 1'b1;
                if (k_q != K_LAST) begin
                    issue    = 1'b1;
                    act_addr = AW'(k_q);
                    w_addr   = WAW'(n_q) * W_STRIDE + WAW'(k_q);
                    k_d      = k_q + KW'(1);
                end else begin
                    // Last slot's data is presented by the pipe this cycle.
                    k_d     = '0;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                busy          = 1'b1;
                nrn_output_en = 1'b1;
                state_d       = WB;
            end
            WB: begin
                busy       = 1'b1;
                wb_we      = 1'b1;
                wb_spike   = 1'b1;
                vmem_addr  = n_q;
                vmem_wdata = nrn_out_mem_vol;
                spike_idx  = n_q;
                spike_bit  = nrn_spike;
                if (n_q == N_LAST) begin
                    state_d = DONE;
                end else begin
                    n_d     = n_q + NW'(1);
                    state_d = RD_V;
                end
            end
            DONE: begin
                done    = 1'b1;
                n_d     = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            k_q      <= '0;
            arithm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            arithm_q <= arithm_d;
        end
    end

    // A reset landing on a WB cycle must not commit the write or the report.
    assign vmem_we     = wb_we & ~rst;
    assign spike_valid = wb_spike & ~rst;
    assign nrn_arithm  = arithm_q;

    if_input_stream_pipe #(
        .DW (DW)
    ) u_stream (
        .clk             (clk),
        .rst             (rst),
        .issue           (issue),
        .act_rdata       (act_rdata),
        .w_rdata         (w_rdata),
        .nrn_input_valid (nrn_input_valid),
        .nrn_activation  (nrn_activation),
        .nrn_weight      (nrn_weight)
    );

endmodule

// File: tb/tb_if_layer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_if_layer_sequencer
// Directed bench for if_layer_sequencer with N_NEURONS=2, N_INPUTS=4.
// Memories and a table-driven neuron are modelled here; a per-cycle timeline
// model derives every expected output from the pass offset.
// ----------------------------------------------------------------------------
module tb_if_layer_sequencer;

    localparam int NN   = 2;
    localparam int NI   = 4;
    localparam int VW   = 16;
    localparam int DW   = 8;
    localparam int AW   = 2;
    localparam int WAW  = 3;
    localparam int NW   = 1;
    localparam int P    = NI + 5;
    localparam int LAST = NN * P + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           arithm_mode;
    logic           busy, done;
    logic [AW-1:0]  act_addr;
    logic [DW-1:0]  act_rdata;
    logic [WAW-1:0] w_addr;
    logic [DW-1:0]  w_rdata;
    logic [NW-1:0]  vmem_addr;
    logic [VW-1:0]  vmem_rdata;
    logic           vmem_we;
    logic [VW-1:0]  vmem_wdata;
    logic           nrn_load_en, nrn_input_valid, nrn_output_en, nrn_arithm;
    logic [DW-1:0]  nrn_activation, nrn_weight;
    logic [VW-1:0]  nrn_input_mem_vol;
    logic [VW-1:0]  nrn_out_mem_vol = '0;
    logic           nrn_spike = 1'b0;
    logic           spike_valid;
    logic [NW-1:0]  spike_idx;
    logic           spike_bit;

    always #5 clk = ~clk;

    if_layer_sequencer #(
        .N_NEURONS (NN),
        .N_INPUTS  (NI),
        .VW        (VW),
        .DW        (DW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .arithm_mode       (arithm_mode),
        .busy              (busy),
        .done              (done),
        .act_addr          (act_addr),
        .act_rdata         (act_rdata),
        .w_addr            (w_addr),
        .w_rdata           (w_rdata),
        .vmem_addr         (vmem_addr),
        .vmem_rdata        (vmem_rdata),
        .vmem_we           (vmem_we),
        .vmem_wdata        (vmem_wdata),
        .nrn_load_en       (nrn_load_en),
        .nrn_input_valid   (nrn_input_valid),
        .nrn_output_en     (nrn_output_en),
        .nrn_arithm        (nrn_arithm),
        .nrn_activation    (nrn_activation),
        .nrn_weight        (nrn_weight),
        .nrn_input_mem_vol (nrn_input_mem_vol),
        .nrn_out_mem_vol   (nrn_out_mem_vol),
        .nrn_spike         (nrn_spike),
        .spike_valid       (spike_valid),
        .spike_idx         (spike_idx),
        .spike_bit         (spike_bit)
    );

    // Environment: synchronous-read memories and a table-driven neuron.
    logic [DW-1:0] act_mem [NI];
    logic [DW-1:0] w_mem   [NN*NI];
    logic [VW-1:0] vmem    [NN];
    logic [VW-1:0] out_tab [4] = '{16'h0021, 16'h0050, 16'h1234, 16'h0ABC};
    logic          spk_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int            fire_cnt = 0;

    always @(posedge clk) begin
        act_rdata  <= act_mem[act_addr];
        w_rdata    <= w_mem[w_addr];
        vmem_rdata <= vmem[vmem_addr];
        if (vmem_we) vmem[vmem_addr] <= vmem_wdata;
        if (nrn_output_en) begin
            nrn_out_mem_vol <= out_tab[fire_cnt % 4];
            nrn_spike       <= spk_tab[fire_cnt % 4];
            fire_cnt        <= fire_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Timeline model state
    bit            mdl_on = 1'b0;
    bit            in_pass = 1'b0;
    int            t = 0;
    int            start_cyc = 0;
    int            exp_fire = 0;
    logic [DW-1:0] exp_act = '0;
    logic [DW-1:0] exp_w = '0;
    logic          exp_arith = 1'b0;
    int            m_n, m_j, m_s, m_k, wi;
    bit            e_busy, e_done, e_load, e_val, e_oen, e_wb, e_rdv, e_issue;

    // Observed-event logs (offsets relative to the accepted start cycle)
    int ld_q[$], iv_q[$], oe_q[$], we_q[$], done_q[$], done_abs[$];
    int wa_log[$], wd_log[$], si_log[$], sb_log[$], waq[$], aaq[$];

    task automatic clear_logs();
        ld_q.delete(); iv_q.delete(); oe_q.delete(); we_q.delete();
        done_q.delete(); done_abs.delete(); wa_log.delete(); wd_log.delete();
        si_log.delete(); sb_log.delete(); waq.delete(); aaq.delete();
    endtask

    always @(negedge clk) begin
        if (mdl_on) begin
            e_busy = 0; e_done = 0; e_load = 0; e_val = 0;
            e_oen = 0; e_wb = 0; e_rdv = 0; e_issue = 0;
            m_n = 0; m_j = 0; m_s = 0; m_k = 0;
            if (in_pass) begin
                if (t == LAST) begin
                    e_done = 1;
                end else begin
                    e_busy = 1;
                    m_n    = (t - 1) / P;
                    m_j    = (t - 1) % P;
                    e_rdv  = (m_j == 0);
                    e_load = (m_j == 1);
                    if (m_j >= 2 && m_j <= NI + 1) begin
                        e_issue = 1;
                        m_k     = m_j - 2;
                    end
                    if (m_j >= 3 && m_j <= NI + 2) begin
                        m_s   = m_j - 3;
                        e_val = 1;
`ifdef SKIP_ZERO_ACT_EN
                        if (act_mem[m_s] == '0) e_val = 0;
`endif
                    end
                    e_oen = (m_j == NI + 3);
                    e_wb  = (m_j == NI + 4);
                end
            end
            if (e_val) begin
                exp_act = act_mem[m_s];
                exp_w   = w_mem[m_n * NI + m_s];
            end

            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("load_en", 32'(nrn_load_en), 32'(e_load));
            chk("input_valid", 32'(nrn_input_valid), 32'(e_val));
            chk("output_en", 32'(nrn_output_en), 32'(e_oen));
            chk("vmem_we", 32'(vmem_we), 32'(e_wb && !rst));
            chk("spike_valid", 32'(spike_valid), 32'(e_wb && !rst));
            chk("activation", 32'(nrn_activation), 32'(exp_act));
            chk("weight", 32'(nrn_weight), 32'(exp_w));
            chk("arithm", 32'(nrn_arithm), 32'(exp_arith));
            if (e_load) chk("load_vol", 32'(nrn_input_mem_vol), 32'(vmem[m_n]));
            if (e_issue) begin
                chk("act_addr", 32'(act_addr), 32'(m_k));
                chk("w_addr", 32'(w_addr), 32'(m_n * NI + m_k));
            end
            if (e_rdv || e_wb) chk("vmem_addr", 32'(vmem_addr), 32'(m_n));
            if (e_wb && !rst && exp_fire > 0) begin
                wi = (exp_fire - 1) % 4;
                chk("vmem_wdata", 32'(vmem_wdata), 32'(out_tab[wi]));
                chk("spike_idx", 32'(spike_idx), 32'(m_n));
                chk("spike_bit", 32'(spike_bit), 32'(spk_tab[wi]));
            end

            if (nrn_load_en) ld_q.push_back(cyc - start_cyc);
            if (nrn_input_valid) iv_q.push_back(cyc - start_cyc);
            if (nrn_output_en) oe_q.push_back(cyc - start_cyc);
            if (vmem_we) begin
                we_q.push_back(cyc - start_cyc);
                wa_log.push_back(int'(vmem_addr));
                wd_log.push_back(int'(vmem_wdata));
            end
            if (spike_valid) begin
                si_log.push_back(int'(spike_idx));
                sb_log.push_back(int'(spike_bit));
            end
            if (done) begin
                done_q.push_back(cyc - start_cyc);
                done_abs.push_back(cyc);
            end
            if (in_pass && t >= 12 && t <= 15) begin
                waq.push_back(int'(w_addr));
                aaq.push_back(int'(act_addr));
            end

            if (e_oen) exp_fire++;
            if (rst) begin
                in_pass   = 0;
                t         = 0;
                exp_act   = '0;
                exp_w     = '0;
                exp_arith = 1'b0;
            end else if (!in_pass) begin
                if (start) begin
                    in_pass   = 1;
                    t         = 1;
                    start_cyc = cyc;
                    exp_arith = arithm_mode;
                end
            end else if (t == LAST) begin
                in_pass = 0;
                t       = 0;
            end else begin
                t++;
            end
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_pass(input logic mode);
        arithm_mode = mode;
        start       = 1'b1;
        tick(1);
        start       = 1'b0;
        arithm_mode = 1'b0;
        for (int i = 0; i < 100 && done_q.size() == 0; i++) tick(1);
        if (done_q.size() == 0) chk("pass_done_timeout", 32'd0, 32'd1);
        tick(3);
    endtask

    int c0;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        arithm_mode = 1'b0;
        act_mem     = '{8'd0, 8'd3, 8'd0, 8'd5};
        w_mem       = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h23, 8'h24};
        vmem[0]     = 16'h0100;
        vmem[1]     = 16'h0200;

        @(posedge clk);
        #1;
        mdl_on = 1'b1;
        tick(1);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_vmem_we", 32'(vmem_we), 32'd0);
        chk("rst_load_en", 32'(nrn_load_en), 32'd0);
        chk("rst_spike_valid", 32'(spike_valid), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_activation", 32'(nrn_activation), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Pass 1: strobe timing, addresses, write-back, spike reports
        clear_logs();
        run_pass(1'b1);
        chk("p1_load_cycle", 32'(qget(ld_q, 0)), 32'd2);
        chk("p1_output_en_cycle", 32'(qget(oe_q, 0)), 32'd8);
        chk("p1_vmem_we_cycle", 32'(qget(we_q, 0)), 32'd9);
        chk("p1_done_cycle", 32'(qget(done_q, 0)), 32'd19);
`ifdef SKIP_ZERO_ACT_EN
        chk("p1_valid_count", 32'(iv_q.size()), 32'd4);
        chk("p1_valid_first", 32'(qget(iv_q, 0)), 32'd5);
        chk("p1_valid_second", 32'(qget(iv_q, 1)), 32'd7);
`else
        chk("p1_valid_count", 32'(iv_q.size()), 32'd8);
        chk("p1_valid_first", 32'(qget(iv_q, 0)), 32'd4);
        chk("p1_valid_fourth", 32'(qget(iv_q, 3)), 32'd7);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("n1_w_addr", 32'(qget(waq, i)), 32'(4 + i));
            chk("n1_act_addr", 32'(qget(aaq, i)), 32'(i));
        end
        chk("p1_wr0_addr", 32'(qget(wa_log, 0)), 32'd0);
        chk("p1_wr0_data", 32'(qget(wd_log, 0)), 32'h0021);
        chk("p1_wr1_addr", 32'(qget(wa_log, 1)), 32'd1);
        chk("p1_wr1_data", 32'(qget(wd_log, 1)), 32'h0050);
        chk("p1_spk0", 32'(qget(si_log, 0) * 2 + qget(sb_log, 0)), 32'd1);
        chk("p1_spk1", 32'(qget(si_log, 1) * 2 + qget(sb_log, 1)), 32'd2);

        // Pass 2: new activations, reloads written-back voltages
        act_mem = '{8'd7, 8'd0, 8'd9, 8'd2};
        clear_logs();
        run_pass(1'b0);
        chk("p2_done_cycle", 32'(qget(done_q, 0)), 32'd19);
        chk("p2_wr0_data", 32'(qget(wd_log, 0)), 32'h1234);
        chk("p2_wr1_data", 32'(qget(wd_log, 1)), 32'h0ABC);
        chk("p2_spk1_bit", 32'(qget(sb_log, 1)), 32'd1);

        // Pass 3: start held high; each pass must begin from IDLE
        clear_logs();
        c0    = cyc;
        start = 1'b1;
        tick(40);
        start = 1'b0;
        tick(5);
        chk("held_done_count", 32'(done_abs.size()), 32'd2);
        chk("held_done0", 32'(qget(done_abs, 0) - c0), 32'd19);
        chk("held_done1", 32'(qget(done_abs, 1) - c0), 32'd39);

        // Pass 4: reset during ACC of neuron 1
        clear_logs();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(12);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_strobes", 32'({nrn_load_en, nrn_input_valid, nrn_output_en}), 32'd0);
        chk("midrst_vmem_we", 32'(vmem_we), 32'd0);
        tick(30);
        chk("midrst_write_count", 32'(we_q.size()), 32'd1);
        chk("midrst_no_done", 32'(done_q.size()), 32'd0);

        // Pass 5: normal pass after the aborted one
        clear_logs();
        run_pass(1'b1);
        chk("p5_done_cycle", 32'(qget(done_q, 0)), 32'd19);
        chk("p5_write_count", 32'(we_q.size()), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
